ppu_sprite_line_engine: RTL and testbench

Parametrised per-scanline sprite engine for the PPU.
- On a `start_line` request it scans OAM for sprites that intersect the requested line. It keeps up to `MAX_PER_LINE` of them, in OAM-index priority order.
- It then fetches each selected sprite's graphics row into per-slot row registers.
- It then serves a palette index per screen pixel to the pixel mixer.
- It sits between the OAM / sprite-graphics RAMs and the background/sprite mixer, and is driven by the PPU line sequencer during horizontal blanking.

---
 rtl/ppu_sprite_line_engine.sv | 209 ++++++++++++++++++++
 tb/tb_ppu_sprite_line_engine.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_sprite_line_engine.sv
// Per-scanline sprite engine: scans OAM for sprites on a line, fetches one
// graphics row per selected sprite, then serves a palette index per pixel.
module ppu_sprite_line_engine #(
  parameter int NUM_SPRITES  = 32,
  parameter int MAX_PER_LINE = 8,
  parameter int SPRITE_W     = 16,
  parameter int SPRITE_H     = 16,
  parameter int BPP          = 2,
  parameter int GFX_AW       = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_line,
  input  logic [9:0]        line_y,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [7:0]        oam_addr,
  input  logic [31:0]       oam_data,
  output logic [GFX_AW-1:0] gfx_addr,
  input  logic [31:0]       gfx_data,
  input  logic [9:0]        px,
  output logic [BPP-1:0]    pix_index,
  output logic [1:0]        pix_palette
);

  localparam int ROW_W  = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int COL_W  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int SLOT_W = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
  localparam logic [8:0] NUM_S9 = 9'(NUM_SPRITES);
  localparam logic [8:0] MAX_S9 = 9'(MAX_PER_LINE);
  localparam logic [9:0] H10    = 10'(SPRITE_H);
  localparam logic [9:0] W10    = 10'(SPRITE_W);

  typedef enum logic [1:0] {IDLE, SCAN, FETCH, READY} state_t;

  state_t state_reg, state_next;

  logic [9:0]        line_y_reg;
  logic [8:0]        cnt_reg;      // cycle index inside SCAN / FETCH
  logic [8:0]        count_reg;    // number of filled slots
  logic              overflow_reg;
  logic              done_reg;
  logic [7:0]        oam_addr_reg;
  logic [GFX_AW-1:0] gfx_addr_reg;
  logic [BPP-1:0]    pix_index_reg;
  logic [1:0]        pix_palette_reg;

  logic [9:0]       slot_x_reg    [MAX_PER_LINE];
  logic [5:0]       slot_tile_reg [MAX_PER_LINE];
  logic [1:0]       slot_pal_reg  [MAX_PER_LINE];
  logic             slot_flip_reg [MAX_PER_LINE];
  logic [ROW_W-1:0] slot_row_reg  [MAX_PER_LINE];
  logic [31:0]      slot_gfx_reg  [MAX_PER_LINE];

  // Decode of the OAM word returned for the previous scan address
  logic [9:0]       word_diff;
  logic             word_hit;
  logic [ROW_W-1:0] word_row;
  assign word_diff = line_y_reg - {1'b0, oam_data[18:10]};
  assign word_hit  = oam_data[28] && (word_diff < H10);
  assign word_row  = word_diff[ROW_W-1:0];

  logic [8:0]        cnt_m1, cnt_p1;
  logic [SLOT_W-1:0] cap_slot, next_slot, fill_slot;
  assign cnt_m1    = cnt_reg - 9'd1;
  assign cnt_p1    = cnt_reg + 9'd1;
  assign cap_slot  = cnt_m1[SLOT_W-1:0];
  assign next_slot = cnt_p1[SLOT_W-1:0];
  assign fill_slot = count_reg[SLOT_W-1:0];

  function automatic logic [GFX_AW-1:0] gfx_of(input logic [5:0] tile, input logic [ROW_W-1:0] row);
    logic [31:0] a;
    a = 32'(tile) * 32'(SPRITE_H) + 32'(row);
    return a[GFX_AW-1:0];
  endfunction

  // Horizontally mirrored copy of the incoming graphics word
  logic [31:0] gfx_flipped;
  for (genvar gi = 0; gi < SPRITE_W; gi++) begin : g_flip
    assign gfx_flipped[gi*BPP +: BPP] = gfx_data[(SPRITE_W-1-gi)*BPP +: BPP];
  end

  // Per-slot coverage and pixel lookup for the current px
  logic [MAX_PER_LINE-1:0] slot_cover;
  logic [BPP-1:0]          slot_pix [MAX_PER_LINE];
  for (genvar gi = 0; gi < MAX_PER_LINE; gi++) begin : g_slot
    logic [9:0]  d;
    logic [31:0] shifted;
    assign d              = px - slot_x_reg[gi];
    assign shifted        = slot_gfx_reg[gi] >> (32'(d[COL_W-1:0]) * 32'(BPP));
    assign slot_pix[gi]   = shifted[BPP-1:0];
    assign slot_cover[gi] = (9'(gi) < count_reg) && (d < W10) && (slot_pix[gi] != '0);
  end

  // Lowest-numbered opaque covering slot wins
  logic [BPP-1:0] win_index;
  logic [1:0]     win_palette;
  always_comb begin
    win_index   = '0;
    win_palette = '0;
    for (int i = MAX_PER_LINE - 1; i >= 0; i--) begin
      if (slot_cover[i]) begin
        win_index   = slot_pix[i];
        win_palette = slot_pal_reg[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; a start request restarts from any state
  always_comb begin
    state_next = state_reg;
    if (start_line) begin
      state_next = SCAN;
    end else begin
      case (state_reg)
        SCAN:    if (cnt_reg == NUM_S9)    state_next = FETCH;
        FETCH:   if (cnt_reg == count_reg) state_next = READY;
        default: state_next = state_reg;
      endcase
    end
  end

  // Scan, fetch and pixel datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      line_y_reg      <= '0;
      cnt_reg         <= '0;
      count_reg       <= '0;
      overflow_reg    <= 1'b0;
      done_reg        <= 1'b0;
      oam_addr_reg    <= '0;
      gfx_addr_reg    <= '0;
      pix_index_reg   <= '0;
      pix_palette_reg <= '0;
    end else begin
      done_reg        <= 1'b0;
      pix_index_reg   <= '0;
      pix_palette_reg <= '0;
      if (start_line) begin
        line_y_reg   <= line_y;
        cnt_reg      <= '0;
        count_reg    <= '0;
        overflow_reg <= 1'b0;
        oam_addr_reg <= '0;
      end else begin
        case (state_reg)
          SCAN: begin
            if (cnt_reg != 9'd0 && word_hit) begin
              if (count_reg < MAX_S9) begin
                slot_x_reg[fill_slot]    <= oam_data[9:0];
                slot_tile_reg[fill_slot] <= oam_data[24:19];
                slot_pal_reg[fill_slot]  <= oam_data[26:25];
                slot_flip_reg[fill_slot] <= oam_data[27];
                slot_row_reg[fill_slot]  <= word_row;
                count_reg                <= count_reg + 9'd1;
              end else begin
                overflow_reg <= 1'b1;
              end
            end
            if (cnt_reg == NUM_S9) begin
              cnt_reg <= '0;
              // Slot 0 may be the word being stored on this very edge
              if (count_reg != 9'd0)
                gfx_addr_reg <= gfx_of(slot_tile_reg[0], slot_row_reg[0]);
              else if (word_hit)
                gfx_addr_reg <= gfx_of(oam_data[24:19], word_row);
            end else begin
              cnt_reg <= cnt_p1;
              if (cnt_p1 < NUM_S9) oam_addr_reg <= cnt_p1[7:0];
            end
          end
          FETCH: begin
            if (cnt_reg != 9'd0)
              slot_gfx_reg[cap_slot] <= slot_flip_reg[cap_slot] ? gfx_flipped : gfx_data;
            if (cnt_reg == count_reg) begin
              cnt_reg  <= '0;
              done_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_p1;
              if (cnt_p1 < count_reg)
                gfx_addr_reg <= gfx_of(slot_tile_reg[next_slot], slot_row_reg[next_slot]);
            end
          end
          READY: begin
            pix_index_reg   <= win_index;
            pix_palette_reg <= win_palette;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy        = (state_reg == SCAN) || (state_reg == FETCH);
  assign done        = done_reg;
  assign overflow    = overflow_reg;
  assign oam_addr    = oam_addr_reg;
  assign gfx_addr    = gfx_addr_reg;
  assign pix_index   = pix_index_reg;
  assign pix_palette = pix_palette_reg;

endmodule

// File: tb/tb_ppu_sprite_line_engine.sv
// Directed bench for ppu_sprite_line_engine with synchronous OAM and
// graphics memory models and immediate-assertion checks.
module tb_ppu_sprite_line_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_line;
  logic [9:0]  line_y;
  logic        busy, done, overflow;
  logic [7:0]  oam_addr;
  logic [31:0] oam_data;
  logic [10:0] gfx_addr;
  logic [31:0] gfx_data;
  logic [9:0]  px;
  logic [1:0]  pix_index;
  logic [1:0]  pix_palette;

  logic [31:0] oam_mem [0:255];
  logic [31:0] gfx_mem [0:2047];

  int n_assert = 0;
  int n_fail   = 0;

  ppu_sprite_line_engine dut (
    .clk(clk), .reset(reset), .start_line(start_line), .line_y(line_y),
    .busy(busy), .done(done), .overflow(overflow),
    .oam_addr(oam_addr), .oam_data(oam_data),
    .gfx_addr(gfx_addr), .gfx_data(gfx_data),
    .px(px), .pix_index(pix_index), .pix_palette(pix_palette)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory models
  always @(posedge clk) begin
    oam_data <= oam_mem[oam_addr];
    gfx_data <= gfx_mem[gfx_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int x, input int y, input int tile, input int pal, input int hf);
    return {3'b000, 1'b1, hf[0], pal[1:0], tile[5:0], y[8:0], x[9:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 256; i++) oam_mem[i] = 32'h0;
  endtask

  // Build one line and check done latency, pulse width and busy coverage
  task automatic run_line(input string tag, input int ly, input int exp_cnt);
    int n;
    int busy_low;
    bit got;
    n = 0; busy_low = 0; got = 0;
    line_y = 10'(ly);
    start_line = 1'b1;
    tick();
    start_line = 1'b0;
    chk({tag, "_ovf_clr"}, 32'(overflow), 32'd0);
    while (!got && n < 80) begin
      if (!busy) busy_low++;
      tick();
      n++;
      if (done) got = 1;
      if (done && busy) busy_low++;
    end
    $display("line %0d (%s): done after %0d edges", ly, tag, n);
    chk({tag, "_done_lat"}, 32'(n), 32'(34 + exp_cnt));
    chk({tag, "_busy_span"}, 32'(busy_low), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
  endtask

  task automatic check_px(input string tag, input int x, input int exp_idx, input int exp_pal);
    px = 10'(x);
    tick();
    chk({tag, "_idx"}, 32'(pix_index), 32'(exp_idx));
    chk({tag, "_pal"}, 32'(pix_palette), 32'(exp_pal));
  endtask

  initial begin
    int first_done;
    int dones;
    reset = 1'b1; start_line = 1'b0; line_y = '0; px = '0;
    clear_oam();
    for (int i = 0; i < 2048; i++) gfx_mem[i] = 32'h0;
    repeat (3) tick();
    chk("rst_outputs", {26'd0, busy, done, overflow, pix_index, pix_palette}, 32'd0);
    chk("rst_oam_addr", 32'(oam_addr), 32'd0);
    chk("rst_gfx_addr", 32'(gfx_addr), 32'd0);
    reset = 1'b0;
    tick();

    // Single sprite
    oam_mem[3] = mk(100, 50, 2, 1, 0);
    gfx_mem[2*16+5] = 32'h0000_0003;
    run_line("single", 55, 1);
    chk("single_ovf", 32'(overflow), 32'd0);
    check_px("single_x100", 100, 3, 1);
    check_px("single_x99", 99, 0, 0);
    check_px("single_x101", 101, 0, 0);

    // Priority
    clear_oam();
    oam_mem[0] = mk(200, 20, 4, 2, 0);
    oam_mem[1] = mk(200, 20, 5, 3, 0);
    gfx_mem[64] = 32'h2;
    gfx_mem[80] = 32'h1;
    run_line("prio", 20, 2);
    check_px("prio_front", 200, 2, 2);
    gfx_mem[64] = 32'h0;
    run_line("prio2", 20, 2);
    check_px("prio_behind", 200, 1, 3);

    // Overflow
    clear_oam();
    for (int i = 0; i < 10; i++) begin
      oam_mem[i] = mk(300 + 20*i, 20, i, i % 4, 0);
      gfx_mem[i*16] = 32'h1;
    end
    run_line("ovf", 20, 8);
    chk("ovf_set", 32'(overflow), 32'd1);
    check_px("ovf_slot7", 440, 1, 3);
    check_px("ovf_slot0", 300, 1, 0);
    check_px("ovf_dropped8", 460, 0, 0);
    run_line("ovf_again", 20, 8);

    // Vertical boundaries
    clear_oam();
    oam_mem[5] = mk(100, 40, 7, 0, 0);
    gfx_mem[7*16+0]  = 32'h1;
    gfx_mem[7*16+15] = 32'h2;
    run_line("top", 40, 1);
    check_px("top_row0", 100, 1, 0);
    run_line("bottom", 55, 1);
    check_px("bottom_row15", 100, 2, 0);
    run_line("above", 39, 0);
    check_px("above_miss", 100, 0, 0);
    run_line("below", 56, 0);
    check_px("below_miss", 100, 0, 0);

    // Horizontal flip
    oam_mem[5] = mk(100, 40, 7, 1, 1);
    gfx_mem[7*16+0] = 32'h1;
    run_line("flip", 40, 1);
    check_px("flip_x115", 115, 1, 1);
    check_px("flip_x100", 100, 0, 0);

    // Right-edge clipping
    oam_mem[5] = mk(630, 40, 8, 0, 0);
    gfx_mem[128] = 32'hFFFF_FFFF;
    run_line("edge", 40, 1);
    check_px("edge_x630", 630, 3, 0);
    check_px("edge_x639", 639, 3, 0);
    check_px("edge_x629", 629, 0, 0);
    check_px("edge_x0", 0, 0, 0);
    check_px("edge_x5", 5, 0, 0);

    // Abort during FETCH
    clear_oam();
    oam_mem[3] = mk(100, 50, 2, 1, 0);
    line_y = 10'd55;
    start_line = 1'b1;
    tick();
    start_line = 1'b0;
    repeat (33) tick();
    chk("abort_in_fetch_busy", 32'(busy), 32'd1);
    start_line = 1'b1;
    tick();
    start_line = 1'b0;
    first_done = 0; dones = 0;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (done) begin
        dones++;
        if (first_done == 0) first_done = n;
      end
    end
    $display("abort restart: %0d done pulses, first after %0d edges", dones, first_done);
    chk("abort_done_lat", 32'(first_done), 32'd35);
    chk("abort_done_cnt", 32'(dones), 32'd1);
    check_px("abort_px", 100, 3, 1);

    // Reset mid-SCAN
    line_y = 10'd55;
    start_line = 1'b1;
    tick();
    start_line = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    chk("rstscan_outputs", {26'd0, busy, done, overflow, pix_index, pix_palette}, 32'd0);
    chk("rstscan_oam_addr", 32'(oam_addr), 32'd0);
    chk("rstscan_gfx_addr", 32'(gfx_addr), 32'd0);
    reset = 1'b0;
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (done || busy) dones++;
    end
    $display("reset mid-scan: %0d active cycles afterwards", dones);
    chk("rstscan_quiet", 32'(dones), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
